// File: rtl/booth_wallace_mac_pipe.sv
// booth_wallace_mac_pipe
// Pipelined radix-4 Booth / carry-save multiply-accumulate unit for the PE
// datapath. It takes signed or unsigned operands and has four register stages:
// operand capture, Booth partial products, carry-save reduction, and
// carry-propagate add plus accumulate.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle
//   in_a       multiplicand (WIDTH)
//   in_b       multiplier (WIDTH)
//   in_signed  1: two's complement operands, 0: unsigned
//   in_mode    00 MUL, 01 MAC, 10 MSU, 11 LOAD
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_result result (ACC_WIDTH)
//   acc_ovf    sticky saturation flag
//
// Configuration
//   SATURATE_EN  when defined, MAC/MSU results clamp to the representable
//                range and set acc_ovf. When undefined, arithmetic wraps and
//                acc_ovf is tied low.
module booth_wallace_mac_pipe #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_result,
  output logic                 acc_ovf
);

  localparam int EW  = WIDTH + 2;
  localparam int NPP = WIDTH/2 + 1;
  localparam int PW  = 2*WIDTH;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_MAC  = 2'b01,
    MODE_MSU  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  logic           r_s1Valid, r_s1Signed;
  logic [EW-1:0]  r_s1A, r_s1B;
  mode_t          r_s1Mode;

  // Operand capture. Both operands widen by two bits so that every later stage
  // can treat them as signed, whatever the requested signedness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid  <= 1'b0;
      r_s1Signed <= 1'b0;
      r_s1A      <= '0;
      r_s1B      <= '0;
      r_s1Mode   <= MODE_MUL;
    end else if (!w_stall) begin
      r_s1Valid  <= in_valid;
      r_s1Signed <= in_signed;
      r_s1A      <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
      r_s1B      <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
      r_s1Mode   <= mode_t'(in_mode);
    end
  end

  // One radix-4 Booth digit times the multiplicand, shifted into position.
  // A negative digit takes the two's complement of the full row, so every
  // row is an exact term of the product modulo 2^PW.
  function automatic logic [PW-1:0] boothPp(input logic [2:0] grp,
                                            input logic [PW-1:0] mcand,
                                            input int shift);
    logic [PW-1:0] mag;
    case (grp)
      3'b001, 3'b010, 3'b101, 3'b110: mag = mcand;
      3'b011, 3'b100:                 mag = mcand << 1;
      default:                        mag = '0;
    endcase
    if (grp[2]) mag = ~mag + PW'(1);
    return mag << shift;
  endfunction

  logic [PW-1:0] w_mcand;
  logic [EW:0]   w_bExt;
  logic [PW-1:0] w_pp [NPP];
  assign w_mcand = {{(PW-EW){r_s1A[EW-1]}}, r_s1A};
  assign w_bExt  = {r_s1B, 1'b0};

  // Encode overlapping 3-bit windows of the multiplier, with an implicit zero
  // below bit 0. This gives WIDTH/2+1 partial products.
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      w_pp[i] = boothPp(w_bExt[2*i +: 3], w_mcand, 2*i);
    end
  end

  logic           r_s2Valid, r_s2Signed;
  logic [PW-1:0]  r_s2Pp [NPP];
  mode_t          r_s2Mode;

  // Partial-product register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_s2Signed <= 1'b0;
      r_s2Mode   <= MODE_MUL;
      for (int i = 0; i < NPP; i++) r_s2Pp[i] <= '0;
    end else if (!w_stall) begin
      r_s2Valid  <= r_s1Valid;
      r_s2Signed <= r_s1Signed;
      r_s2Mode   <= r_s1Mode;
      for (int i = 0; i < NPP; i++) r_s2Pp[i] <= w_pp[i];
    end
  end

  logic [PW-1:0] w_csaSum, w_csaCarry, w_csaNextSum;

  // 3:2 carry-save reduction of all partial products into a sum/carry pair.
  // The carry row is stored already shifted left by one. Bits that move past
  // PW are dropped because the product is taken modulo 2^PW.
  always_comb begin
    w_csaSum     = r_s2Pp[0];
    w_csaCarry   = r_s2Pp[1];
    w_csaNextSum = '0;
    for (int i = 2; i < NPP; i++) begin
      w_csaNextSum = w_csaSum ^ w_csaCarry ^ r_s2Pp[i];
      w_csaCarry   = ((w_csaSum & w_csaCarry) | (w_csaSum & r_s2Pp[i]) |
                      (w_csaCarry & r_s2Pp[i])) << 1;
      w_csaSum     = w_csaNextSum;
    end
  end

  logic           r_s3Valid, r_s3Signed;
  logic [PW-1:0]  r_s3Sum, r_s3Carry;
  mode_t          r_s3Mode;

  // Carry-save register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3Valid  <= 1'b0;
      r_s3Signed <= 1'b0;
      r_s3Sum    <= '0;
      r_s3Carry  <= '0;
      r_s3Mode   <= MODE_MUL;
    end else if (!w_stall) begin
      r_s3Valid  <= r_s2Valid;
      r_s3Signed <= r_s2Signed;
      r_s3Sum    <= w_csaSum;
      r_s3Carry  <= w_csaCarry;
      r_s3Mode   <= r_s2Mode;
    end
  end

  logic [PW-1:0]        w_product;
  logic [ACC_WIDTH-1:0] w_pExt, w_accNext, w_resNext;
  logic [ACC_WIDTH-1:0] r_acc, r_result;
  logic                 r_outValid;

  assign w_product = r_s3Sum + r_s3Carry;
  assign w_pExt    = r_s3Signed ? ACC_WIDTH'($signed(w_product)) : ACC_WIDTH'(w_product);

`ifdef SATURATE_EN
  localparam int XW = ACC_WIDTH + 2;
  logic [XW-1:0] w_accWide, w_pWide, w_sumWide;
  logic          w_clamp;
  logic          r_ovf;

  // MAC/MSU run two bits wider than the accumulator so an out-of-range
  // result can be detected and clamped to the signed or unsigned limit.
  always_comb begin
    w_accWide = r_s3Signed ? XW'($signed(r_acc))  : XW'(r_acc);
    w_pWide   = r_s3Signed ? XW'($signed(w_pExt)) : XW'(w_pExt);
    w_sumWide = (r_s3Mode == MODE_MSU) ? (w_accWide - w_pWide) : (w_accWide + w_pWide);
    w_clamp   = 1'b0;
    w_accNext = r_acc;
    w_resNext = w_pExt;
    case (r_s3Mode)
      MODE_MAC, MODE_MSU: begin
        if (r_s3Signed) begin
          if (w_sumWide[XW-1:ACC_WIDTH-1] != {(XW-ACC_WIDTH+1){w_sumWide[XW-1]}}) begin
            w_clamp   = 1'b1;
            w_accNext = w_sumWide[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end else begin
            w_accNext = w_sumWide[ACC_WIDTH-1:0];
          end
        end else begin
          if (w_sumWide[XW-1:ACC_WIDTH] != '0) begin
            w_clamp   = 1'b1;
            w_accNext = w_sumWide[XW-1] ? '0 : '1;
          end else begin
            w_accNext = w_sumWide[ACC_WIDTH-1:0];
          end
        end
        w_resNext = w_accNext;
      end
      MODE_LOAD: w_accNext = w_pExt;
      default:   w_accNext = r_acc;
    endcase
  end

  // Sticky overflow. Only a LOAD or a reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_stall && r_s3Valid) begin
      if (r_s3Mode == MODE_LOAD) r_ovf <= 1'b0;
      else if (w_clamp)          r_ovf <= 1'b1;
    end
  end

  assign acc_ovf = r_ovf;
`else
  // Wrap-around accumulate for each operation mode.
  always_comb begin
    w_accNext = r_acc;
    w_resNext = w_pExt;
    case (r_s3Mode)
      MODE_MAC: begin
        w_accNext = r_acc + w_pExt;
        w_resNext = w_accNext;
      end
      MODE_MSU: begin
        w_accNext = r_acc - w_pExt;
        w_resNext = w_accNext;
      end
      MODE_LOAD: w_accNext = w_pExt;
      default:   w_accNext = r_acc;
    endcase
  end

  assign acc_ovf = 1'b0;
`endif

  // Output and accumulator stage. Only a valid beat changes the accumulator,
  // so a bubble leaves it untouched. A stall freezes it together with the
  // rest of the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_acc      <= '0;
    end else if (!w_stall) begin
      r_outValid <= r_s3Valid;
      if (r_s3Valid) begin
        r_acc    <= w_accNext;
        r_result <= w_resNext;
      end
    end
  end

  assign out_valid  = r_outValid;
  assign out_result = r_result;

endmodule

// File: tb/tb_booth_wallace_mac_pipe.sv
// tb_booth_wallace_mac_pipe
// Directed-vector bench for booth_wallace_mac_pipe (WIDTH=32, ACC_WIDTH=72).
// Each beat pushes its hand-computed result onto a queue. A negedge monitor
// pops the queue on every output handshake. While the output is stalled, the
// monitor checks that the head result is held.
module tb_booth_wallace_mac_pipe;

  localparam logic [1:0] MUL  = 2'b00;
  localparam logic [1:0] MAC  = 2'b01;
  localparam logic [1:0] MSU  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inReady, inSigned, outValid, outReady, accOvf;
  logic [31:0] inA, inB;
  logic [1:0]  inMode;
  logic [71:0] outResult;

  int          vecCount = 0;
  int          errCount = 0;
  logic [71:0] expQ [$];
  string       tagQ [$];

  always #5 clk = ~clk;

  booth_wallace_mac_pipe #(.WIDTH(32), .ACC_WIDTH(72)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_a       (inA),
    .in_b       (inB),
    .in_signed  (inSigned),
    .in_mode    (inMode),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_result (outResult),
    .acc_ovf    (accOvf)
  );

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // The output monitor pops one expected value per handshake. While the output
  // is stalled, it checks the head value without popping it.
  always @(negedge clk) begin
    if (rst_n && outValid) begin
      if (!outReady) begin
        if (expQ.size() != 0) checkOutput({"hold ", tagQ[0]}, outResult, expQ[0]);
      end else if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 72'd1, 72'd0);
      end else begin
        checkOutput(tagQ.pop_front(), outResult, expQ.pop_front());
      end
    end
  end

  // Presents one beat for exactly one acceptance edge. The task starts and
  // ends 1 time unit after a rising edge.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic sgn,
                               input logic [1:0] mode, input logic [71:0] expected);
    int waitCount = 0;
    while (!inReady && waitCount < 50) begin
      @(posedge clk); #1;
      waitCount++;
    end
    if (!inReady) checkOutput({"accept_timeout ", tag}, 72'd0, 72'd1);
    inValid  = 1'b1;
    inA      = a;
    inB      = b;
    inSigned = sgn;
    inMode   = mode;
    expQ.push_back(expected);
    tagQ.push_back(tag);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic drainOutputs();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 72'(expQ.size()), 72'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time %0t reached, limit 2000000", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [71:0] e;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    inSigned = 1'b0;
    inMode   = MUL;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 72'(outValid), 72'd0);
    checkOutput("rst_out_result", outResult, 72'd0);
    checkOutput("rst_acc_ovf", 72'(accOvf), 72'd0);
    checkOutput("rst_in_ready", 72'(inReady), 72'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: the acceptance edge plus three more edges fill the four
    // register stages.
    applyStimulus("mul_s_-3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, MUL, 72'hFF_FFFF_FFFF_FFFF_FFEB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("lat_not_early", 72'(outValid), 72'd0);
    @(posedge clk); #1;
    checkOutput("lat_valid", 72'(outValid), 72'd1);
    drainOutputs();

    applyStimulus("mul_u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL, 72'h00_FFFF_FFFE_0000_0001);
    applyStimulus("mul_s_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, MUL, 72'd1);
    drainOutputs();

    applyStimulus("load_2x3", 32'd2, 32'd3, 1'b1, LOAD, 72'd6);
    applyStimulus("mac_4x5", 32'd4, 32'd5, 1'b1, MAC, 72'd26);
    applyStimulus("msu_1x6", 32'd1, 32'd6, 1'b1, MSU, 72'd20);
    applyStimulus("mul_9x9", 32'd9, 32'd9, 1'b1, MUL, 72'd81);
    applyStimulus("acc_after_mul", 32'd0, 32'd0, 1'b1, MAC, 72'd20);
    drainOutputs();

    // A LOAD and four MACs back-to-back. The output stalls for three cycles
    // once the first MAC reaches it.
    applyStimulus("st_load_1", 32'd1, 32'd1, 1'b0, LOAD, 72'd1);
    applyStimulus("st_mac_2x3", 32'd2, 32'd3, 1'b0, MAC, 72'd7);
    applyStimulus("st_mac_4x5", 32'd4, 32'd5, 1'b0, MAC, 72'd27);
    applyStimulus("st_mac_1x1", 32'd1, 32'd1, 1'b0, MAC, 72'd28);
    applyStimulus("st_mac_10x10", 32'd10, 32'd10, 1'b0, MAC, 72'd128);
    outReady = 1'b0;
    checkOutput("stall_out_valid", 72'(outValid), 72'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_in_ready", 72'(inReady), 72'd0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    #1;
    checkOutput("unstall_in_ready", 72'(inReady), 72'd1);
    drainOutputs();

    // A reset with three beats in flight discards all three.
    applyStimulus("fl_a", 32'd3, 32'd3, 1'b0, MAC, 72'd137);
    applyStimulus("fl_b", 32'd3, 32'd3, 1'b0, MAC, 72'd146);
    applyStimulus("fl_c", 32'd3, 32'd3, 1'b0, MAC, 72'd155);
    rst_n = 1'b0;
    expQ.delete();
    tagQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rst_flush_valid", 72'(outValid), 72'd0);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus("post_rst_mac_5x5", 32'd5, 32'd5, 1'b0, MAC, 72'd25);
    drainOutputs();

    // Repeated (-2^31)*(-2^31) = 2^62. After 512 MACs the sum reaches 2^71.
    applyStimulus("sat_load_0", 32'd0, 32'd0, 1'b1, LOAD, 72'd0);
    for (int k = 1; k <= 512; k++) begin
      e = 72'(k) << 62;
`ifdef SATURATE_EN
      if (k == 512) e = {1'b0, {71{1'b1}}};
`endif
      applyStimulus("big_mac", 32'h8000_0000, 32'h8000_0000, 1'b1, MAC, e);
    end
    drainOutputs();
`ifdef SATURATE_EN
    checkOutput("acc_ovf_after", 72'(accOvf), 72'd1);
`else
    checkOutput("acc_ovf_after", 72'(accOvf), 72'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
